// File: rtl/ex_muldiv_pkg.sv
// Shared op/state encodings and default sizing for the multiply/divide sequencer.
package ex_muldiv_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_CNT_DEF  = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_sequencer_core.sv
// One-bit-per-cycle shift datapath: radix-2 shift-add multiply and restoring divide
// on unsigned magnitudes; acc is the product high half / partial remainder.
module muldiv_core #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [NB_DATA-1:0] i_opnd,
  input  logic [NB_DATA-1:0] i_init,
  output logic [NB_DATA-1:0] o_acc,
  output logic [NB_DATA-1:0] o_sh
);

  logic [NB_DATA-1:0] acc_q, acc_d;
  logic [NB_DATA-1:0] sh_q, sh_d;
  logic [NB_DATA-1:0] opnd_q, opnd_d;
  logic [NB_DATA-1:0] addend;
  logic [NB_DATA-1:0] diff;
  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   trial;

  // trial is the NB_DATA+1 bit shifted remainder; once it fits the divisor the
  // difference is below the divisor, so modular NB_DATA-bit subtraction is exact.
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    addend = sh_q[0] ? opnd_q : '0;
    sum    = {1'b0, acc_q} + {1'b0, addend};
    trial  = {acc_q, sh_q[NB_DATA-1]};
    diff   = trial[NB_DATA-1:0] - opnd_q;
    if (i_load) begin
      acc_d  = '0;
      sh_d   = i_init;
      opnd_d = i_opnd;
    end else if (i_step) begin
      if (i_div) begin
        if (trial >= {1'b0, opnd_q}) begin
          acc_d = diff;
          sh_d  = {sh_q[NB_DATA-2:0], 1'b1};
        end else begin
          acc_d = trial[NB_DATA-1:0];
          sh_d  = {sh_q[NB_DATA-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[NB_DATA:1];
        sh_d  = {sum[0], sh_q[NB_DATA-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
    end
  end

  assign o_acc = acc_q;
  assign o_sh  = sh_q;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall control.
// Optional EX_MULDIV_EARLY_TERM_EN: multiplies finish once remaining multiplier bits are zero.
module ex_muldiv_sequencer
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_CNT  = NB_CNT_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int unsigned NB_PROD = 2 * NB_DATA;

  md_state_e          state_q, state_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_DATA-1:0] hi_q, hi_d;
  logic [NB_DATA-1:0] lo_q, lo_d;
  logic               done_q, done_d;
  logic               sgn_quo_q, sgn_quo_d;
  logic               sgn_rem_q, sgn_rem_d;
  logic               div0_q, div0_d;
  logic               op_div_q, op_div_d;

  md_op_e             op;
  logic               is_signed;
  logic               is_div;
  logic [NB_DATA-1:0] mag_a, mag_b;
  logic               core_load, core_step, core_div;
  logic [NB_DATA-1:0] core_opnd, core_init;
  logic [NB_DATA-1:0] core_acc, core_sh;
  logic               mul_last;
  logic [NB_PROD-1:0] prod, prod_s;

  assign op        = md_op_e'(i_op);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign mag_a     = (is_signed && i_datoA[NB_DATA-1]) ? -i_datoA : i_datoA;
  assign mag_b     = (is_signed && i_datoB[NB_DATA-1]) ? -i_datoB : i_datoB;
  assign core_opnd = is_div ? mag_b : mag_a;
  assign core_init = is_div ? mag_a : mag_b;
  assign core_div  = (state_q == ST_DIV);

  muldiv_core #(
    .NB_DATA (NB_DATA)
  ) u_core (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (core_load),
    .i_step  (core_step),
    .i_div   (core_div),
    .i_opnd  (core_opnd),
    .i_init  (core_init),
    .o_acc   (core_acc),
    .o_sh    (core_sh)
  );

`ifdef EX_MULDIV_EARLY_TERM_EN
  // Unconsumed multiplier bits sit in core_sh[cnt-1:0]; the product is still
  // right-aligned short by cnt positions when the loop exits early.
  logic [NB_DATA-1:0] rest_mask;
  assign rest_mask = (NB_DATA'(1) << (cnt_q - NB_CNT'(1))) - NB_DATA'(1);
  assign mul_last  = (cnt_q == NB_CNT'(1)) || (((core_sh >> 1) & rest_mask) == '0);
  assign prod      = {core_acc, core_sh} >> cnt_q;
`else
  assign mul_last  = (cnt_q == NB_CNT'(1));
  assign prod      = {core_acc, core_sh};
`endif

  assign prod_s = sgn_quo_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    div0_d    = div0_q;
    op_div_d  = op_div_q;
    core_load = 1'b0;
    core_step = 1'b0;
    if (i_halt) begin
      done_d = done_q;
    end else if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                core_load = 1'b1;
                cnt_d     = NB_CNT'(NB_DATA);
                state_d   = is_div ? ST_DIV : ST_MUL;
                sgn_quo_d = is_signed & (i_datoA[NB_DATA-1] ^ i_datoB[NB_DATA-1]);
                sgn_rem_d = is_signed & i_datoA[NB_DATA-1];
                div0_d    = is_div && (i_datoB == '0);
                op_div_d  = is_div;
              end
              MD_MTHI: hi_d = i_datoA;
              MD_MTLO: lo_d = i_datoA;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          core_step = 1'b1;
          cnt_d     = cnt_q - NB_CNT'(1);
          if (mul_last) state_d = ST_FIX;
        end
        ST_DIV: begin
          core_step = 1'b1;
          cnt_d     = cnt_q - NB_CNT'(1);
          if (cnt_q == NB_CNT'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          // Divide by zero leaves all-ones quotient and the signed dividend as remainder.
          if (op_div_q) begin
            lo_d = div0_q ? '1 : (sgn_quo_q ? -core_sh : core_sh);
            hi_d = sgn_rem_q ? -core_acc : core_acc;
          end else begin
            hi_d = prod_s[NB_PROD-1:NB_DATA];
            lo_d = prod_s[NB_DATA-1:0];
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      op_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      div0_q    <= div0_d;
      op_div_q  <= op_div_d;
    end
  end

  assign o_busy   = i_rst_n && (state_q != ST_IDLE);
  assign o_stall  = i_rst_n && ((state_q != ST_IDLE) || (i_start && !i_op[2]));
  assign o_result = (!i_rst_n || state_q != ST_IDLE || !i_start) ? '0 :
                    (op == MD_MFHI) ? hi_q :
                    (op == MD_MFLO) ? lo_q : '0;
  assign o_done   = done_q;
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomized bench for ex_muldiv_sequencer against an arithmetic reference model,
// plus directed literal checks. Honors EX_MULDIV_EARLY_TERM_EN for multiply latency.
module tb_ex_muldiv_sequencer;
  import ex_muldiv_pkg::*;

`ifdef EX_MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_M23 = EARLY ? 3 : 33;

  logic        clk;
  logic        i_rst_n, i_halt, i_flush, i_start;
  logic [2:0]  i_op;
  logic [31:0] i_datoA, i_datoB;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_result, o_hi, o_lo;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  ex_muldiv_sequencer dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_halt   (i_halt),
    .i_flush  (i_flush),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_datoA  (i_datoA),
    .i_datoB  (i_datoB),
    .o_stall  (o_stall),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_hi     (o_hi),
    .o_lo     (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: p = 64'(longint'(sa) * longint'(sb));
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] mb;
    int top;
    mb  = (op == 3'd0 && b[31]) ? -b : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) top = i;
    return (EARLY && op < 3'd2) ? top + 2 : 33;
  endfunction

  // Behavioural model: m_left counts cycles until the pending result lands.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;
  logic        m_done;

  always @(posedge clk) begin
    if (!i_rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else if (i_halt) begin
      m_left <= m_left;
    end else if (i_flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (i_start) begin
        if (i_op < 3'd4) begin
          m_pend <= model_res(i_op, i_datoA, i_datoB);
          m_left <= model_lat(i_op, i_datoB);
        end else if (i_op == 3'd6) m_hi <= i_datoA;
        else if (i_op == 3'd7) m_lo <= i_datoA;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(o_busy), 32'(i_rst_n && m_left > 0));
      check("stall", 32'(o_stall), 32'(i_rst_n && (m_left > 0 || (i_start && i_op < 3'd4))));
      check("done", 32'(o_done), 32'(m_done));
      check("hi", o_hi, m_hi);
      check("lo", o_lo, m_lo);
      check("result", o_result,
            (!i_rst_n || m_left > 0 || !i_start) ? 32'd0 :
            (i_op == 3'd4) ? m_hi : (i_op == 3'd5) ? m_lo : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div, optionally halting 5 cycles; measures latency, stalls and done pulses.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int halt_at, output int lat, output int stalls, output int dones);
    lat = -1; stalls = 0; dones = 0;
    i_start = 1'b1; i_op = op; i_datoA = a; i_datoB = b;
    #1;
    if (o_stall) stalls++;
    tick();
    i_start = 1'b0; i_datoA = '0; i_datoB = '0;
    for (int n = 0; n < 45; n++) begin
      i_halt = (halt_at >= 0) && (n >= halt_at) && (n < halt_at + 5);
      #1;
      if (o_stall) stalls++;
      if (o_done) begin
        dones++;
        if (lat < 0) lat = n;
      end
      tick();
    end
    i_halt = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int lat, stalls, dones, stalled;
    i_rst_n = 1'b0; i_halt = 1'b0; i_flush = 1'b0; i_start = 1'b0;
    i_op = '0; i_datoA = '0; i_datoB = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_hi", o_hi, 32'd0);
    check("rst_lo", o_lo, 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_rst_n = 1'b1;
    tick();

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, -1, lat, stalls, dones);
    check("mult_lat", 32'(lat), 32'(LAT_M23));
    check("mult_stalls", 32'(stalls), 32'(LAT_M23 + 1));
    check("mult_dones", 32'(dones), 32'd1);
    check("mult_hi", o_hi, 32'hFFFF_FFFF);
    check("mult_lo", o_lo, 32'hFFFF_FFFA);

    run_op(MD_DIVU, 32'd100, 32'd7, -1, lat, stalls, dones);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_lo", o_lo, 32'd14);
    check("divu_hi", o_hi, 32'd2);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, lat, stalls, dones);
    check("div_neg_lo", o_lo, 32'hFFFF_FFFD);
    check("div_neg_hi", o_hi, 32'hFFFF_FFFF);

    run_op(MD_DIV, 32'd5, 32'd0, -1, lat, stalls, dones);
    check("div0_lat", 32'(lat), 32'd33);
    check("div0_lo", o_lo, 32'hFFFF_FFFF);
    check("div0_hi", o_hi, 32'd5);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, stalls, dones);
    check("divmin_lo", o_lo, 32'h8000_0000);
    check("divmin_hi", o_hi, 32'd0);

    // Flush at iteration 10 of a long multiply.
    i_start = 1'b1; i_op = MD_MULTU; i_datoA = 32'hFFFF_FFFF; i_datoB = 32'hFFFF_FFFF;
    tick();
    i_start = 1'b0;
    repeat (10) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #1;
    check("flush_busy", 32'(o_busy), 32'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (o_done) dones++;
      tick();
    end
    check("flush_dones", 32'(dones), 32'd0);
    check("flush_hi", o_hi, 32'd0);
    check("flush_lo", o_lo, 32'h8000_0000);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, lat, stalls, dones);
    check("halt_lat", 32'(lat), 32'd38);
    check("halt_dones", 32'(dones), 32'd1);
    check("halt_hi", o_hi, 32'hFFFF_FFFE);
    check("halt_lo", o_lo, 32'h0000_0001);

    i_start = 1'b1; i_op = MD_MTHI; i_datoA = 32'h1234;
    tick();
    i_op = MD_MFHI; i_datoA = '0;
    #1;
    check("mfhi_result", o_result, 32'h1234);
    check("mfhi_stall", 32'(o_stall), 32'd0);
    i_start = 1'b0;
    tick();

    // MFLO presented while a multiply is in flight.
    i_start = 1'b1; i_op = MD_MULTU; i_datoA = 32'd7; i_datoB = 32'h8000_0006;
    tick();
    i_op = MD_MFLO; i_datoA = '0; i_datoB = '0;
    stalled = 0;
    for (int n = 0; n < 45; n++) begin
      #1;
      if (!o_stall) break;
      stalled++;
      tick();
    end
    check("mflo_stalled", 32'(stalled), 32'd33);
    check("mflo_result", o_result, 32'h8000_002A);
    i_start = 1'b0;
    tick();
    check("mflo_hi", o_hi, 32'd3);

    // Reset at iteration 20 of a divide.
    i_start = 1'b1; i_op = MD_DIV; i_datoA = 32'd100; i_datoB = 32'd7;
    tick();
    i_start = 1'b0;
    repeat (20) tick();
    i_rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(o_busy), 32'd0);
    tick();
    i_rst_n = 1'b1;
    #1;
    check("rstmid_busy2", 32'(o_busy), 32'd0);
    check("rstmid_hi", o_hi, 32'd0);
    check("rstmid_lo", o_lo, 32'd0);
    tick();

`ifdef EX_MULDIV_EARLY_TERM_EN
    run_op(MD_MULT, 32'd9, 32'd1, -1, lat, stalls, dones);
    check("early_lat", 32'(lat), 32'd2);
    check("early_lo", o_lo, 32'd9);
    run_op(MD_MULT, 32'd9, 32'd0, -1, lat, stalls, dones);
    check("early_x0_lat", 32'(lat), 32'd2);
`endif

    for (int c = 0; c < 4000; c++) begin
      i_rst_n = ($urandom_range(0, 199) != 0);
      i_halt  = ($urandom_range(0, 99) < 4);
      i_flush = ($urandom_range(0, 199) < 2);
      i_start = ($urandom_range(0, 2) != 0);
      i_op    = 3'($urandom_range(0, 7));
      i_datoA = pick();
      i_datoB = pick();
      tick();
    end

    i_rst_n = 1'b1; i_halt = 1'b0; i_flush = 1'b0; i_start = 1'b0;
    repeat (45) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
